// File: rtl/ahb_ram_slave.sv
// AHB3-Lite single-port RAM slave with configurable wait states.
// Misaligned, oversized and out-of-range transfers get a two-cycle ERROR response.
module ahb_ram_slave #(
  parameter int WORDS = 256,
  parameter int WAIT  = 0
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_hsel_i,
  input  logic [31:0] s_haddr_i,
  input  logic [1:0]  s_htrans_i,
  input  logic        s_hwrite_i,
  input  logic [2:0]  s_hsize_i,
  input  logic [31:0] s_hwdata_i,
  input  logic        s_hready_i,
  output logic [31:0] s_hrdata_o,
  output logic        s_hreadyout_o,
  output logic        s_hresp_o
);

  localparam int          AW         = $clog2(WORDS);
  localparam logic [31:0] WORD_LIMIT = 32'(WORDS);
  localparam logic [2:0]  WAIT_CNT   = 3'(WAIT);

  // state    | meaning
  // ST_IDLE  | no data phase, or zero-wait data phase completing now
  // ST_WAIT  | wait-state data phase; completes when cnt reaches 0
  // ST_ERR1  | first ERROR cycle (hreadyout low)
  // ST_ERR2  | second ERROR cycle (hreadyout high)
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t          state, state_nxt;
  logic [2:0]      cnt, cnt_nxt;
  logic            dp_valid, dp_valid_nxt;
  logic            dp_write;
  logic [1:0]      dp_size;
  logic [1:0]      dp_lane;
  logic [AW-1:0]   dp_idx;

  logic [31:0]     mem [WORDS];

  logic            ready;
  logic            resp;
  logic            accept;
  logic            addr_err;
  logic            complete;
  logic            wr_en;
  logic [3:0]      be;

  always_comb begin
    addr_err = 1'b0;
    case (s_hsize_i)
      3'd0:    addr_err = 1'b0;
      3'd1:    addr_err = s_haddr_i[0];
      3'd2:    addr_err = (s_haddr_i[1:0] != 2'b00);
      default: addr_err = 1'b1;
    endcase
    if ({2'b00, s_haddr_i[31:2]} >= WORD_LIMIT) addr_err = 1'b1;
  end

  // Gating with our own ready keeps a stalled data phase immune to address-bus changes.
  assign accept = s_hsel_i & s_hready_i & s_htrans_i[1] & ready;

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_size  <= 2'd0;
      dp_lane  <= 2'd0;
      dp_idx   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dp_valid <= dp_valid_nxt;
      if (accept) begin
        dp_write <= s_hwrite_i;
        dp_size  <= s_hsize_i[1:0];
        dp_lane  <= s_haddr_i[1:0];
        dp_idx   <= s_haddr_i[AW+1:2];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dp_valid_nxt = dp_valid;
    if (ready) begin
      dp_valid_nxt = accept & ~addr_err;
      cnt_nxt      = 3'd0;
      state_nxt    = ST_IDLE;
      if (accept) begin
        if (addr_err) begin
          state_nxt = ST_ERR1;
        end else if (WAIT_CNT != 3'd0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = WAIT_CNT;
        end
      end
    end else if (state == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end else begin
      cnt_nxt = cnt - 3'd1;
    end
  end

  always_comb begin
    ready = 1'b1;
    resp  = 1'b0;
    case (state)
      ST_WAIT: ready = (cnt == 3'd0);
      ST_ERR1: begin
        ready = 1'b0;
        resp  = 1'b1;
      end
      ST_ERR2: resp = 1'b1;
      default: ;
    endcase
    complete = dp_valid & ready;
    wr_en    = complete & dp_write & ~s_reset_i;
    case (dp_size)
      2'd0:    be = 4'b0001 << dp_lane;
      2'd1:    be = dp_lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    s_hrdata_o    = (complete & ~dp_write) ? mem[dp_idx] : 32'h0;
    s_hreadyout_o = ready;
    s_hresp_o     = resp;
  end

  // Memory has no reset; contents survive s_reset_i.
  always_ff @(posedge s_clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[dp_idx][8*b +: 8] <= s_hwdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/ahb_ram_slave.md
AHB_RAM_SLAVE -- requirements
Module: ahb_ram_slave

Interface
REQ-001 SHALL have parameter WORDS, default 256; memory depth in 32-bit words, power of two, 4..65536.
REQ-002 SHALL have parameter WAIT, default 0; wait states inserted per OKAY transfer, 0..7.
REQ-003 s_clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 s_reset_i  input  1  synchronous, active-high reset.
REQ-005 s_hsel_i  input  1  slave select from interconnect decoder.
REQ-006 s_haddr_i  input  32  AHB3-Lite address; byte address.
REQ-007 s_htrans_i  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-008 s_hwrite_i  input  1  1 write, 0 read.
REQ-009 s_hsize_i  input  3  0 byte, 1 halfword, 2 word, greater than 2 illegal.
REQ-010 s_hwdata_i  input  32  write data, valid in data phase.
REQ-011 s_hready_i  input  1  bus HREADY; previous transfer on the bus completes.
REQ-012 s_hrdata_o  output  32  read data.
REQ-013 s_hreadyout_o  output  1  this slave's ready.
REQ-014 s_hresp_o  output  1  0 OKAY, 1 ERROR.

Function
REQ-015 Address phase accepted only when s_hsel_i=1, s_hready_i=1 and s_htrans_i[1]=1 (NONSEQ/SEQ); control sampled into registers.
REQ-016 IDLE/BUSY, unselected, or s_hready_i=0: no transfer; next cycle s_hreadyout_o=1, s_hresp_o=0.
REQ-017 Error on accept: s_hsize_i>2; halfword with haddr[0]=1; word with haddr[1:0]!=0; haddr[31:2]>=WORDS.
REQ-018 Data-phase FSM states: IDLE, WAIT, ERR1, ERR2; reset state IDLE.
REQ-019 Accept, no error, WAIT=0 -> IDLE (response in the following cycle: hreadyout=1, hresp=0).
REQ-020 Accept, no error, WAIT>0 -> WAIT with counter=WAIT; s_hreadyout_o=0 while counter>0.
REQ-021 Counter decrements by 1 each WAIT cycle; at 0: hreadyout=1, hresp=0, transfer completes; no underflow.
REQ-022 Accept with error -> ERR1: hreadyout=0, hresp=1; then ERR2: hreadyout=1, hresp=1; then IDLE or new accept.
REQ-023 An errored transfer SHALL NOT modify memory.
REQ-024 Write commits s_hwdata_i at rising edge ending the completing data-phase cycle (hreadyout=1).
REQ-025 Byte lanes: byte writes lane haddr[1:0]; halfword writes lanes {haddr[1],0} and {haddr[1],1}; word writes all four; other lanes unchanged.
REQ-026 Read: s_hrdata_o = full 32-bit word at registered index in completing data-phase cycle; otherwise 32'h0.
REQ-027 Read issued back-to-back after a write to same word SHALL return the newly written data (write visible before the read's data phase).
REQ-028 New address phase SHALL be accepted in the completing cycle of the current data phase (pipelined, zero bubble at WAIT=0).
REQ-029 Throughput at WAIT=N: one transfer per N+1 cycles when back-to-back.
REQ-030 Address/control changes while hreadyout=0 SHALL be ignored (sampled only per REQ-015).

Reset
REQ-031 Reset: FSM IDLE, counter 0, s_hreadyout_o=1, s_hresp_o=0, s_hrdata_o=0, registered control cleared.
REQ-032 Reset mid-transfer (WAIT, ERR1, ERR2) SHALL abandon it; pending write SHALL NOT commit.
REQ-033 Memory contents SHALL NOT be reset; read before write returns undefined data.

Verification
REQ-034 WAIT=0: word write 32'hDEADBEEF to 0x10, then read 0x10 back-to-back -> hreadyout stays 1, read data 32'hDEADBEEF, hresp=0.
REQ-035 WAIT=2: word read 0x20 -> hreadyout 0,0,1 across data phase; hrdata valid only in third cycle.
REQ-036 Word write 32'h11223344 to 0x40, byte write 8'hAA (hwdata 32'h00AA0000) to 0x42, halfword write 16'h5566 (hwdata 32'h00005566) to 0x40 -> read 0x40 returns 32'h11AA5566.
REQ-037 Word access to 0x41; hsize=3 to 0x00; WORDS=256 access to 0x400 -> each: hreadyout 0/hresp 1 then hreadyout 1/hresp 1; memory unchanged.
REQ-038 WAIT=3 write in progress, s_reset_i=1 in second wait cycle -> next cycle hreadyout=1, hresp=0; later read of address returns prior contents.
REQ-039 htrans=IDLE or BUSY with hsel=1, or NONSEQ with hready_i=0 -> hreadyout=1, hresp=0, no memory change.
